// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM state encodings,
// parity selection codes, line idle level and the parity helper.
package uart_pkg;

  // FSM state encodings (kept as plain constants for legacy tooling).
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity type select values on par_typ.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Level of the serial line between frames (mark).
  localparam logic IDLE_LEVEL = 1'b1;

  // Parity over a word of up to 9 bits. Narrower words are zero-extended
  // by the caller, which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [8:0] d, input logic typ);
    logic p;
    p = ^d;
    return (typ == PAR_EVEN) ? p : ~p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time prescaler: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_tick on the final count of each serial bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = enable && !clear && (cnt == CNT_LAST);

  // Prescale counter: wraps at the end of each bit, held at zero when cleared.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: accepts one word over a valid/ready handshake and
// serialises it as start, data LSB-first, optional parity, 1 or 2 stop bits.
// The line is driven straight from a register so it never glitches.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  ready,
  output logic                  busy,
  output logic                  tx_out,
  output logic                  tx_done
);

  localparam int              IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_cnt;   // 0 = first stop bit, 1 = second
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_bit_r;
  logic                  par_en_r;
  logic                  stop2_r;
  logic                  tx_r;
  logic                  bit_tick;
  logic                  last_stop;

  // Words are only taken in IDLE, so everything on the inputs is ignored
  // while a frame is in flight.
  assign ready     = (state == S_IDLE);
  assign busy      = !ready;
  assign tx_out    = tx_r;
  // With one stop bit the first one is final; with two, the second is.
  assign last_stop = (stop_cnt == stop2_r);
  // Suppressed under reset so an abandoned frame never reports completion.
  assign tx_done   = (state == S_STOP) && bit_tick && last_stop && !reset;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .enable   (state != S_IDLE),
    .clear    (state == S_IDLE),
    .bit_tick (bit_tick)
  );

  // Frame sequencer together with its shift, parity and line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too, not just the FSM, so the
      // line and the latched frame settings never come up as X after reset.
      state     <= S_IDLE;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      shift_r   <= '0;
      par_bit_r <= 1'b0;
      par_en_r  <= 1'b0;
      stop2_r   <= 1'b0;
      tx_r      <= IDLE_LEVEL;
    end else begin
      case (state)
        S_IDLE: begin
          tx_r <= IDLE_LEVEL;
          if (data_valid) begin
            state     <= S_START;
            tx_r      <= ~IDLE_LEVEL;
            shift_r   <= p_data;
            par_bit_r <= calc_parity(9'(p_data), par_typ);
            par_en_r  <= par_en;
            stop2_r   <= stop2;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
          end
        end

        S_START: begin
          if (bit_tick) begin
            state   <= S_DATA;
            tx_r    <= shift_r[0];
            shift_r <= shift_r >> 1;
          end
        end

        S_DATA: begin
          if (bit_tick) begin
            if (bit_idx == IDX_LAST) begin
              if (par_en_r) begin
                state <= S_PARITY;
                tx_r  <= par_bit_r;
              end else begin
                state <= S_STOP;
                tx_r  <= IDLE_LEVEL;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_r    <= shift_r[0];
              shift_r <= shift_r >> 1;
            end
          end
        end

        S_PARITY: begin
          if (bit_tick) begin
            state <= S_STOP;
            tx_r  <= IDLE_LEVEL;
          end
        end

        S_STOP: begin
          if (bit_tick) begin
            if (last_stop) begin
              state <= S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          tx_r  <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule
